fifo_stream_reader: RTL
=======================

# fifo_stream_reader

Drain-side adapter for the team's synchronous FIFO: it pops words using the FIFO's `r_en`/`empty`/`data_out` interface and presents them as a valid/ready stream. The FIFO's read data is registered, so it appears one cycle after `r_en`. A 3-entry skid buffer absorbs that latency and sustains one word per cycle with no combinational path from `m_ready` to `fifo_r_en`. It sits between `sync_fifo` and any downstream consumer that applies backpressure.

## Interface
- `DATA_WIDTH`, 8, word width; must match the FIFO's `DATA_WIDTH`.
- `CNT_WIDTH`, 16, width of the delivered-word counter.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  DATA_WIDTH  FIFO `data_out`; valid in the cycle after an accepted `r_en`.
- `fifo_r_en`  out  1  FIFO read enable (combinational).
- `m_valid`  out  1  stream word available.
- `m_ready`  in  1  consumer accepts the word.
- `m_data`  out  DATA_WIDTH  stream word (buffer head).
- `flush`  in  1  synchronous discard of all buffered and in-flight words.
- `buf_level`  out  2  buffer occupancy, 0..3.
- `rd_count`  out  CNT_WIDTH  count of words transferred on the stream (`m_valid & m_ready`); wraps modulo 2^CNT_WIDTH.

## Operation
- State:
  - 3-entry circular buffer with head/tail pointers (mod 3) and `occ` 0..3.
  - `inflight` flag: a read was issued in the previous cycle.
- Read issue:
  - `fifo_r_en = rst_n & !flush & !fifo_empty & (occ + inflight < 3)`.
  - This uses registered state only and never depends on `m_ready`.
- `inflight` is set next cycle iff `fifo_r_en` was 1; otherwise cleared.
- Capture: when `inflight=1` and `flush=0`, write `fifo_data` at the tail and advance the tail.
- Output:
  - `m_valid = (occ != 0)`; `m_data` = head entry.
  - On `m_valid & m_ready`, advance the head and increment `rd_count`.
- `occ` update:
  - Capture and pop in the same cycle: `occ` unchanged.
  - Capture only: `occ+1`.
  - Pop only: `occ-1`.
  - `occ` never exceeds 3, guaranteed by the issue rule.
- Flush, while asserted:
  - `fifo_r_en` is forced 0.
  - A stream transfer in the flush cycle still completes and is counted.
  - Next cycle, `occ`, head, tail and `inflight` are all 0.
  - Data returning in the flush cycle is discarded.
- `buf_level = occ`.

## Timing
- Reset (async assert, sync deassert at the next edge):
  - `m_valid=0`, `m_data=0`, `buf_level=0`, `rd_count=0`, `inflight=0`.
  - `fifo_r_en=0` combinationally while `rst_n=0`.
- Latency, from an empty adapter with a non-empty FIFO:
  - `fifo_r_en` in cycle 0; `fifo_data` valid in cycle 1; captured at the end of cycle 1.
  - `m_valid=1` in cycle 2.
  - First word reaches `m_data` 2 cycles after the issue.
- Throughput: with `m_ready` held 1 and the FIFO non-empty, one word per cycle in steady state (`occ=1`, `inflight=1`).
- Backpressure:
  - With `m_ready=0`, `occ` rises to 3 and `fifo_r_en` stops.
  - `m_data` and `m_valid` are stable while `m_valid & !m_ready`.
  - No word is lost or duplicated.
- FIFO goes empty mid-stream: issuing stops; the remaining `occ` words drain normally; `m_valid` falls after the last pop.
- Buffer pointers wrap 2→0.
- `rd_count` wraps to 0 after all-ones.
- Reset asserted mid-operation: all state clears immediately; buffered and in-flight words are lost.

## Test plan
- **Reset and latency:** hold `rst_n=0` with FIFO non-empty → `fifo_r_en=0`, all outputs 0. Release, FIFO holds 0x11 → `fifo_r_en=1` cycle 0, `m_valid=1` with `m_data=0x11` in cycle 2.
- **Full throughput:** FIFO preloaded 0x00..0x0F, `m_ready=1` → 16 consecutive transfers in order, one per cycle after the 2-cycle latency; `rd_count=16`; then `m_valid=0`, `buf_level=0`.
- **Backpressure:** stream 0xA0..0xA7 with `m_ready` toggling 1,0,0,1 repeatedly → output sequence is exactly 0xA0..0xA7; `buf_level` never exceeds 3; `m_data` stable whenever stalled.
- **Stall to full:** `m_ready=0`, FIFO holds 5 words → `buf_level=3`, `fifo_r_en=0` thereafter, FIFO left with 2 words. Raise `m_ready` → all 5 words delivered in order.
- **Flush:** `buf_level=2` and `inflight=1`, assert `flush` one cycle with `m_ready=1` → head word transferred and counted. Next cycle `buf_level=0`, `m_valid=0`; the in-flight word never appears. Reading resumes with the next FIFO word.
- **Counter wrap:** `CNT_WIDTH=4`, transfer 17 words → `rd_count=1`.

Source files
------------

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_reader
// Description : Pops a registered-read sync FIFO into a valid/ready stream
//               through a 3-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  flush,
    output logic [1:0]            buf_level,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    localparam logic [1:0] c_LAST_IDX = 2'd2;

    logic [DATA_WIDTH-1:0] r_mem [0:2];
    logic [1:0]            r_head;
    logic [1:0]            r_tail;
    logic [1:0]            r_occ;
    logic                  r_inflight;
    logic [CNT_WIDTH-1:0]  r_rd_count;

    logic [2:0]            w_committed;
    logic                  w_room;
    logic                  w_capture;
    logic                  w_pop;
    logic [1:0]            w_head_nxt;
    logic [1:0]            w_tail_nxt;
    logic [1:0]            w_occ_nxt;

    // Room is judged on buffered plus in-flight words so a returning word
    // always has a free slot, independent of the consumer's ready.
    assign w_committed = {1'b0, r_occ} + {2'b00, r_inflight};
    assign w_room      = (w_committed < 3'd3);
    assign fifo_r_en   = rst_n & ~flush & ~fifo_empty & w_room;

    assign w_capture   = r_inflight & ~flush;
    assign m_valid     = (r_occ != 2'd0);
    assign w_pop       = m_valid & m_ready;
    assign m_data      = r_mem[r_head];
    assign buf_level   = r_occ;
    assign rd_count    = r_rd_count;

    assign w_head_nxt  = (r_head == c_LAST_IDX) ? 2'd0 : r_head + 2'd1;
    assign w_tail_nxt  = (r_tail == c_LAST_IDX) ? 2'd0 : r_tail + 2'd1;

    always_comb begin
        w_occ_nxt = r_occ;
        case ({w_capture, w_pop})
            2'b10:   w_occ_nxt = r_occ + 2'd1;
            2'b01:   w_occ_nxt = r_occ - 2'd1;
            default: w_occ_nxt = r_occ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
        end else if (flush) begin
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_r_en;
            r_occ      <= w_occ_nxt;
            if (w_capture) begin
                r_tail <= w_tail_nxt;
            end
            if (w_pop) begin
                r_head <= w_head_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_mem[2] <= '0;
        end else if (w_capture) begin
            r_mem[r_tail] <= fifo_data;
        end
    end

    // A transfer in a flush cycle still completes, so counting ignores flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count <= '0;
        end else if (w_pop) begin
            r_rd_count <= r_rd_count + 1'b1;
        end
    end

endmodule
`default_nettype wire
